// File: rtl/axi_txn_tracker_pkg.sv
// Shared definitions for the AXI transaction tracker.
// Holds the AXI ID encodings of the three cache-side sources, the source
// index enum and the ID classification helper.
package axi_txn_tracker_pkg;

  localparam int NumSrc = 3;

  typedef enum logic [1:0] {
    SrcIcache = 2'd0,
    SrcBypass = 2'd1,
    SrcDcache = 2'd2
  } src_e;

  localparam logic [3:0] IdIcache       = 4'b0000;
  localparam logic [1:0] IdBypassPrefix = 2'b10;
  localparam logic [3:0] IdDcache       = 4'b1100;

  typedef struct packed {
    src_e src;
    logic bad;
  } id_class_t;

  // Unknown IDs are flagged and charged to the I$ slot so the counters
  // still balance if the matching response comes back.
  function automatic id_class_t classify_id(input logic [3:0] id);
    id_class_t c;
    c.src = SrcIcache;
    c.bad = 1'b0;
    if (id == IdIcache) begin
      c.src = SrcIcache;
    end else if (id[3:2] == IdBypassPrefix) begin
      c.src = SrcBypass;
    end else if (id == IdDcache) begin
      c.src = SrcDcache;
    end else begin
      c.bad = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/axi_txn_tracker_fifo.sv
// Small FIFO used to hold accepted AW burst lengths.
// Ports: push_i/data_i write side, pop_i/data_o read side (head entry),
// full_o/empty_o status, usage_o registered fill level.
// With FALL_THROUGH set, a push into an empty FIFO is visible on data_o
// in the same cycle and may be popped immediately without being stored.
module axi_txn_tracker_fifo #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 12,
  parameter bit          FALL_THROUGH = 1'b1,
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CntW-1:0]       usage_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  do_push, do_pop, bypass;

  function automatic logic [AddrW-1:0] ptr_inc(input logic [AddrW-1:0] p);
    return (p == AddrW'(DEPTH - 1)) ? '0 : p + AddrW'(1);
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    full_o   = (cnt_q == CntW'(DEPTH));
    empty_o  = (cnt_q == '0) & ~(FALL_THROUGH & push_i);
    data_o   = mem_q[rd_ptr_q];
    if (FALL_THROUGH && cnt_q == '0) data_o = data_i;
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    bypass   = FALL_THROUGH && (cnt_q == '0) && do_push && do_pop;
    if (!bypass) begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      cnt_d = cnt_q + CntW'(1);
      else if (do_pop && !do_push) cnt_d = cnt_q - CntW'(1);
    end
  end

  assign usage_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !bypass) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/axi_txn_tracker.sv
// AXI transaction tracker and issue gate for the cache master port.
// Ports: drain_i blocks new AR/AW; ar_*/aw_* upstream (_i valid, _o ready)
// and downstream (_o valid, _i ready) handshakes; w_*, r_*, b_* monitored
// handshakes; idle_o when nothing is outstanding; err_o sticky protocol error.
module axi_txn_tracker
  import axi_txn_tracker_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned IdWidth        = 4,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               drain_i,
  input  logic               ar_valid_i,
  output logic               ar_ready_o,
  input  logic [IdWidth-1:0] ar_id_i,
  output logic               ar_valid_o,
  input  logic               ar_ready_i,
  input  logic               aw_valid_i,
  output logic               aw_ready_o,
  input  logic [IdWidth-1:0] aw_id_i,
  input  logic [7:0]         aw_len_i,
  output logic               aw_valid_o,
  input  logic               aw_ready_i,
  input  logic               w_valid_i,
  input  logic               w_ready_i,
  input  logic               w_last_i,
  input  logic               r_valid_i,
  input  logic               r_ready_i,
  input  logic               r_last_i,
  input  logic [IdWidth-1:0] r_id_i,
  input  logic               b_valid_i,
  input  logic               b_ready_i,
  input  logic [IdWidth-1:0] b_id_i,
  output logic               idle_o,
  output logic               err_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);
  localparam int unsigned FifoDepth = 3 * MaxOutstanding;
  localparam int unsigned FifoCntW  = $clog2(FifoDepth + 1);

  logic [CntWidth-1:0] rd_cnt_q [NumSrc];
  logic [CntWidth-1:0] rd_cnt_d [NumSrc];
  logic [CntWidth-1:0] wr_cnt_q [NumSrc];
  logic [CntWidth-1:0] wr_cnt_d [NumSrc];
  logic                ar_hold_q, ar_hold_d, aw_hold_q, aw_hold_d;
  logic [7:0]          beat_q, beat_d;
  logic                err_q, err_d;

  id_class_t ar_cls, aw_cls, r_cls, b_cls;
  logic      ar_open, aw_open, ar_hs, aw_hs, r_hs_last, b_hs, w_hs;
  logic      fifo_full, fifo_empty, fifo_pop;
  logic [7:0] head_len;
  logic [FifoCntW-1:0] fifo_usage;
  logic      cnt_zero;

  assign ar_cls = classify_id(ar_id_i);
  assign aw_cls = classify_id(aw_id_i);
  assign r_cls  = classify_id(r_id_i);
  assign b_cls  = classify_id(b_id_i);

  assign ar_open = ~drain_i & (rd_cnt_q[ar_cls.src] < MaxCnt);
  assign aw_open = ~drain_i & (wr_cnt_q[aw_cls.src] < MaxCnt);

  // A presented request stays presented until accepted, even if the gate
  // closes underneath it (drain or a counter reaching the limit).
  assign ar_valid_o = ar_valid_i & (ar_open | ar_hold_q);
  assign ar_ready_o = ar_ready_i & (ar_open | ar_hold_q);
  assign aw_valid_o = aw_valid_i & (aw_open | aw_hold_q);
  assign aw_ready_o = aw_ready_i & (aw_open | aw_hold_q);

  assign ar_hs     = ar_valid_o & ar_ready_i;
  assign aw_hs     = aw_valid_o & aw_ready_i;
  assign r_hs_last = r_valid_i & r_ready_i & r_last_i;
  assign b_hs      = b_valid_i & b_ready_i;
  assign w_hs      = w_valid_i & w_ready_i;

  assign ar_hold_d = ar_valid_o & ~ar_ready_i;
  assign aw_hold_d = aw_valid_o & ~aw_ready_i;

  assign fifo_pop = w_hs & w_last_i;

  axi_txn_tracker_fifo #(
    .DATA_WIDTH  (8),
    .DEPTH       (FifoDepth),
    .FALL_THROUGH(1'b1)
  ) u_len_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (aw_hs),
    .data_i (aw_len_i),
    .pop_i  (fifo_pop),
    .data_o (head_len),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .usage_o(fifo_usage)
  );

  always_comb begin
    err_d  = err_q;
    beat_d = beat_q;
    for (int s = 0; s < NumSrc; s++) begin
      logic rd_inc, rd_dec, wr_inc, wr_dec;
      rd_inc = ar_hs & (int'(ar_cls.src) == s);
      rd_dec = r_hs_last & (int'(r_cls.src) == s);
      wr_inc = aw_hs & (int'(aw_cls.src) == s);
      wr_dec = b_hs & (int'(b_cls.src) == s);
      rd_cnt_d[s] = rd_cnt_q[s];
      wr_cnt_d[s] = wr_cnt_q[s];
      if (rd_inc && !rd_dec) begin
        rd_cnt_d[s] = rd_cnt_q[s] + CntWidth'(1);
      end else if (rd_dec && !rd_inc) begin
        if (rd_cnt_q[s] == '0) err_d = 1'b1;
        else                   rd_cnt_d[s] = rd_cnt_q[s] - CntWidth'(1);
      end
      if (wr_inc && !wr_dec) begin
        wr_cnt_d[s] = wr_cnt_q[s] + CntWidth'(1);
      end else if (wr_dec && !wr_inc) begin
        if (wr_cnt_q[s] == '0) err_d = 1'b1;
        else                   wr_cnt_d[s] = wr_cnt_q[s] - CntWidth'(1);
      end
    end

    if ((ar_hs & ar_cls.bad) | (aw_hs & aw_cls.bad) |
        (r_valid_i & r_ready_i & r_cls.bad) | (b_hs & b_cls.bad)) err_d = 1'b1;
    if (aw_hs & fifo_full) err_d = 1'b1;

    // Beat counting is against the head burst; the fall-through FIFO makes a
    // same-cycle AW visible here as the head.
    if (w_hs) begin
      if (fifo_empty) begin
        err_d = 1'b1;
      end else if (w_last_i) begin
        if (beat_q != head_len) err_d = 1'b1;
        beat_d = '0;
      end else begin
        if (beat_q == head_len) err_d = 1'b1;
        beat_d = beat_q + 8'd1;
      end
    end
  end

  always_comb begin
    cnt_zero = 1'b1;
    for (int s = 0; s < NumSrc; s++) begin
      if (rd_cnt_q[s] != '0 || wr_cnt_q[s] != '0) cnt_zero = 1'b0;
    end
  end

  assign idle_o = cnt_zero & (fifo_usage == '0) & ~ar_hold_q & ~aw_hold_q;
  assign err_o  = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_q  <= '{default: '0};
      wr_cnt_q  <= '{default: '0};
      ar_hold_q <= 1'b0;
      aw_hold_q <= 1'b0;
      beat_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      ar_hold_q <= ar_hold_d;
      aw_hold_q <= aw_hold_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_txn_tracker.sv
module tb_axi_txn_tracker;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       drain_i;
  logic       ar_valid_i, ar_ready_o, ar_valid_o, ar_ready_i;
  logic [3:0] ar_id_i;
  logic       aw_valid_i, aw_ready_o, aw_valid_o, aw_ready_i;
  logic [3:0] aw_id_i;
  logic [7:0] aw_len_i;
  logic       w_valid_i, w_ready_i, w_last_i;
  logic       r_valid_i, r_ready_i, r_last_i;
  logic [3:0] r_id_i;
  logic       b_valid_i, b_ready_i;
  logic [3:0] b_id_i;
  logic       idle_o, err_o;

  int tests = 0;
  int fails = 0;

  axi_txn_tracker #(.MaxOutstanding(4), .IdWidth(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .drain_i(drain_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
    .aw_len_i(aw_len_i), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .w_valid_i(w_valid_i), .w_ready_i(w_ready_i), .w_last_i(w_last_i),
    .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
    .r_id_i(r_id_i), .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
    .b_id_i(b_id_i), .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; drain_i = 1'b0;
    ar_valid_i = 1'b0; ar_id_i = 4'h0; ar_ready_i = 1'b0;
    aw_valid_i = 1'b0; aw_id_i = 4'h0; aw_len_i = 8'h0; aw_ready_i = 1'b0;
    w_valid_i = 1'b0; w_ready_i = 1'b0; w_last_i = 1'b0;
    r_valid_i = 1'b0; r_ready_i = 1'b1; r_last_i = 1'b0; r_id_i = 4'h0;
    b_valid_i = 1'b0; b_ready_i = 1'b1; b_id_i = 4'h0;
    cyc(); cyc();
    chk("rst_idle", 32'(idle_o), 32'd1);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_ar_ready_lo", 32'(ar_ready_o), 32'd0);
    ar_ready_i = 1'b1; aw_ready_i = 1'b1; #1;
    chk("rst_ar_ready_gate", 32'(ar_ready_o), 32'd1);
    chk("rst_aw_ready_gate", 32'(aw_ready_o), 32'd1);
    chk("rst_fifo_usage", 32'(dut.u_len_fifo.usage_o), 32'd0);
    rst_ni = 1'b1;
    cyc();

    // Single D$ read
    ar_valid_i = 1'b1; ar_id_i = 4'b1100; #1;
    chk("ar1_valid_o", 32'(ar_valid_o), 32'd1);
    cyc(); ar_valid_i = 1'b0; #1;
    chk("ar1_cnt2", 32'(dut.rd_cnt_q[2]), 32'd1);
    chk("ar1_idle", 32'(idle_o), 32'd0);
    r_valid_i = 1'b1; r_last_i = 1'b1; r_id_i = 4'b1100;
    cyc(); r_valid_i = 1'b0; #1;
    chk("r1_cnt2", 32'(dut.rd_cnt_q[2]), 32'd0);
    chk("r1_idle", 32'(idle_o), 32'd1);

    // Bypass limit: four accepted, fifth gated until one response
    ar_valid_i = 1'b1; ar_id_i = 4'b1000;
    repeat (4) cyc();
    chk("lim_cnt1", 32'(dut.rd_cnt_q[1]), 32'd4);
    chk("lim_ready_o", 32'(ar_ready_o), 32'd0);
    chk("lim_valid_o", 32'(ar_valid_o), 32'd0);
    r_valid_i = 1'b1; r_id_i = 4'b1011;
    cyc(); r_valid_i = 1'b0; #1;
    chk("lim_cnt1_after_r", 32'(dut.rd_cnt_q[1]), 32'd3);
    chk("lim_fifth_valid", 32'(ar_valid_o), 32'd1);
    chk("lim_fifth_ready", 32'(ar_ready_o), 32'd1);
    cyc(); ar_valid_i = 1'b0; #1;
    chk("lim_cnt1_full", 32'(dut.rd_cnt_q[1]), 32'd4);
    r_valid_i = 1'b1; r_id_i = 4'b1001;
    repeat (4) cyc();
    r_valid_i = 1'b0; #1;
    chk("lim_cnt1_drained", 32'(dut.rd_cnt_q[1]), 32'd0);
    chk("lim_idle", 32'(idle_o), 32'd1);
    chk("lim_err", 32'(err_o), 32'd0);

    // Hold across drain
    ar_valid_i = 1'b1; ar_id_i = 4'b0000; ar_ready_i = 1'b0; #1;
    chk("hold_c1_valid", 32'(ar_valid_o), 32'd1);
    chk("hold_c1_ready", 32'(ar_ready_o), 32'd0);
    cyc(); drain_i = 1'b1; #1;
    chk("hold_c2_valid", 32'(ar_valid_o), 32'd1);
    chk("hold_idle", 32'(idle_o), 32'd0);
    cyc(); #1;
    chk("hold_c3_valid", 32'(ar_valid_o), 32'd1);
    cyc(); ar_ready_i = 1'b1; #1;
    chk("hold_c4_valid", 32'(ar_valid_o), 32'd1);
    chk("hold_c4_ready", 32'(ar_ready_o), 32'd1);
    cyc(); #1;
    chk("hold_cnt0", 32'(dut.rd_cnt_q[0]), 32'd1);
    chk("hold_next_gated_v", 32'(ar_valid_o), 32'd0);
    chk("hold_next_gated_r", 32'(ar_ready_o), 32'd0);
    cyc(); #1;
    chk("hold_cnt0_stable", 32'(dut.rd_cnt_q[0]), 32'd1);
    ar_valid_i = 1'b0; drain_i = 1'b0;
    r_valid_i = 1'b1; r_id_i = 4'b0000;
    cyc(); r_valid_i = 1'b0; #1;
    chk("hold_cnt0_ret", 32'(dut.rd_cnt_q[0]), 32'd0);

    // Same-cycle inc/dec on D$ at count 2
    ar_valid_i = 1'b1; ar_id_i = 4'b1100;
    cyc(); cyc(); #1;
    chk("same_pre_cnt2", 32'(dut.rd_cnt_q[2]), 32'd2);
    r_valid_i = 1'b1; r_id_i = 4'b1100;
    cyc(); ar_valid_i = 1'b0; #1;
    chk("same_cnt2", 32'(dut.rd_cnt_q[2]), 32'd2);
    cyc(); cyc(); r_valid_i = 1'b0; #1;
    chk("same_cnt2_drained", 32'(dut.rd_cnt_q[2]), 32'd0);
    chk("same_err", 32'(err_o), 32'd0);

    // Good write burst, len 3, first beat alongside AW
    aw_valid_i = 1'b1; aw_id_i = 4'b0000; aw_len_i = 8'd3;
    w_valid_i = 1'b1; w_ready_i = 1'b1; w_last_i = 1'b0;
    cyc(); aw_valid_i = 1'b0; #1;
    chk("wr_cnt0", 32'(dut.wr_cnt_q[0]), 32'd1);
    chk("wr_fifo_usage", 32'(dut.u_len_fifo.usage_o), 32'd1);
    chk("wr_beat1", 32'(dut.beat_q), 32'd1);
    cyc(); cyc(); w_last_i = 1'b1;
    cyc(); w_valid_i = 1'b0; w_last_i = 1'b0; #1;
    chk("wr_fifo_empty", 32'(dut.u_len_fifo.usage_o), 32'd0);
    chk("wr_err_ok", 32'(err_o), 32'd0);
    b_valid_i = 1'b1; b_id_i = 4'b0000;
    cyc(); b_valid_i = 1'b0; #1;
    chk("wr_b_cnt0", 32'(dut.wr_cnt_q[0]), 32'd0);
    chk("wr_idle", 32'(idle_o), 32'd1);

    // Early last on beat 2 of a len-3 burst
    aw_valid_i = 1'b1; aw_id_i = 4'b1100; aw_len_i = 8'd3;
    cyc(); aw_valid_i = 1'b0;
    w_valid_i = 1'b1;
    cyc(); cyc(); w_last_i = 1'b1;
    cyc(); w_valid_i = 1'b0; w_last_i = 1'b0; #1;
    chk("early_err", 32'(err_o), 32'd1);
    chk("early_fifo_empty", 32'(dut.u_len_fifo.usage_o), 32'd0);
    b_valid_i = 1'b1; b_id_i = 4'b1100;
    cyc(); b_valid_i = 1'b0;
    cyc(); cyc(); #1;
    chk("early_err_sticky", 32'(err_o), 32'd1);
    chk("early_wr_cnt2", 32'(dut.wr_cnt_q[2]), 32'd0);
    rst_ni = 1'b0; #1;
    chk("early_rst_err", 32'(err_o), 32'd0);
    cyc(); rst_ni = 1'b1;

    // B underflow on I$
    b_valid_i = 1'b1; b_id_i = 4'b0000;
    cyc(); b_valid_i = 1'b0; #1;
    chk("bunder_err", 32'(err_o), 32'd1);
    chk("bunder_cnt0", 32'(dut.wr_cnt_q[0]), 32'd0);
    rst_ni = 1'b0; cyc(); rst_ni = 1'b1;

    // Unknown ID is flagged and charged to source 0
    ar_valid_i = 1'b1; ar_id_i = 4'b0101;
    cyc(); ar_valid_i = 1'b0; #1;
    chk("badid_err", 32'(err_o), 32'd1);
    chk("badid_cnt0", 32'(dut.rd_cnt_q[0]), 32'd1);
    rst_ni = 1'b0; cyc(); rst_ni = 1'b1;

    // W beat with nothing queued
    w_valid_i = 1'b1; w_last_i = 1'b1;
    cyc(); w_valid_i = 1'b0; w_last_i = 1'b0; #1;
    chk("wempty_err", 32'(err_o), 32'd1);
    rst_ni = 1'b0; cyc(); rst_ni = 1'b1;

    // Missing last at beat == len (len 0, single non-last beat)
    aw_valid_i = 1'b1; aw_id_i = 4'b1010; aw_len_i = 8'd0;
    w_valid_i = 1'b1; w_last_i = 1'b0;
    cyc(); aw_valid_i = 1'b0; w_valid_i = 1'b0; #1;
    chk("nolast_err", 32'(err_o), 32'd1);

    // Reset mid-transaction clears asynchronously; late response underflows
    rst_ni = 1'b0; cyc(); rst_ni = 1'b1;
    ar_valid_i = 1'b1; ar_id_i = 4'b1100;
    cyc(); ar_valid_i = 1'b0; #1;
    chk("mid_cnt2_pre", 32'(dut.rd_cnt_q[2]), 32'd1);
    #2 rst_ni = 1'b0; #1;
    chk("mid_cnt2_async", 32'(dut.rd_cnt_q[2]), 32'd0);
    chk("mid_idle_async", 32'(idle_o), 32'd1);
    cyc(); rst_ni = 1'b1;
    r_valid_i = 1'b1; r_last_i = 1'b1; r_id_i = 4'b1100;
    cyc(); r_valid_i = 1'b0; #1;
    chk("mid_late_r_err", 32'(err_o), 32'd1);
    chk("mid_late_r_cnt", 32'(dut.rd_cnt_q[2]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
